// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with single-cycle add/sub/xor/branch compares
// and a 32-iteration shift-add multiply that stalls the front end through busy.
`default_nettype none

module alu_multicycle #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      ALU_control,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] ALU_result,
  output logic            zero,
  output logic            out_valid,
  output logic            busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  localparam logic [3:0] OP_AND0 = 4'd0;
  localparam logic [3:0] OP_MULT = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_BNE  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_BGE  = 4'd7;

  state_t          state;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [4:0]      count;

  logic [XLEN-1:0] alu_res;
  logic            alu_zero;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] acc_next;

  assign diff     = A - B;
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign busy     = (state == MUL);

  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b1;
    case (ALU_control)
      OP_ADD: begin
        alu_res  = A + B;
        alu_zero = (alu_res == '0);
      end
      OP_SUB: begin
        alu_res  = diff;
        alu_zero = (diff == '0);
      end
      OP_XOR: begin
        alu_res  = A ^ B;
        alu_zero = (alu_res == '0);
      end
      OP_BEQ: begin
        alu_res  = diff;
        alu_zero = (A == B);
      end
      OP_BNE: begin
        alu_res  = diff;
        alu_zero = (A != B);
      end
      OP_BGE: begin
        alu_res  = diff;
        alu_zero = ($signed(A) >= $signed(B));
      end
      OP_AND0: begin
        alu_res  = '0;
        alu_zero = 1'b1;
      end
      default: begin
        alu_res  = '0;
        alu_zero = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
      ALU_result <= '0;
      zero       <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (ALU_control == OP_MULT) begin
              mcand  <= A;
              mplier <= B;
              acc    <= '0;
              count  <= '0;
              state  <= MUL;
            end else begin
              ALU_result <= alu_res;
              zero       <= alu_zero;
              out_valid  <= 1'b1;
            end
          end
        end
        MUL: begin
          // The last iteration commits its own partial product straight to the result.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (count == 5'd31) begin
            ALU_result <= acc_next;
            zero       <= (acc_next == '0);
            out_valid  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors with hand-computed results for alu_multicycle.
`default_nettype none

module tb_alu_multicycle;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  ALU_control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALU_result;
  logic        zero;
  logic        out_valid;
  logic        busy;

  int vectors;
  int miscompares;

  alu_multicycle #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .ALU_control(ALU_control),
    .A          (A),
    .B          (B),
    .ALU_result (ALU_result),
    .zero       (zero),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    ALU_control = code;
    A           = a;
    B           = b;
    tick();
  endtask

  // Counts busy cycles after the accept edge until busy drops; also counts stray out_valid.
  task automatic wait_done(output int busy_cycles, output int stray_valid);
    int guard;
    busy_cycles = busy ? 1 : 0;
    stray_valid = 0;
    guard       = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
      if (busy) begin
        busy_cycles++;
        if (out_valid) stray_valid++;
      end
    end
    check("mult_timeout", {31'd0, busy}, 32'd0);
  endtask

  int bc;
  int sv;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b1;
    ALU_control = 4'd2;
    A           = 32'd1;
    B           = 32'd1;

    tick();
    check("rst_result", ALU_result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    check("rst_ov2", {31'd0, out_valid}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("post_rst_ov", {31'd0, out_valid}, 32'd0);

    op(4'd2, 32'h7FFF_FFFF, 32'd1);
    check("add_res", ALU_result, 32'h8000_0000);
    check("add_zero", {31'd0, zero}, 32'd0);
    check("add_ov", {31'd0, out_valid}, 32'd1);
    op(4'd6, 32'd5, 32'd5);
    check("sub_res", ALU_result, 32'd0);
    check("sub_zero", {31'd0, zero}, 32'd1);
    check("sub_ov", {31'd0, out_valid}, 32'd1);
    op(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000);
    check("xor_res", ALU_result, 32'h0F0F_F0F0);
    check("xor_zero", {31'd0, zero}, 32'd0);
    check("xor_ov", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("idle_ov", {31'd0, out_valid}, 32'd0);
    check("idle_hold", ALU_result, 32'h0F0F_F0F0);

    op(4'd5, 32'd9, 32'd9);
    check("beq_zero", {31'd0, zero}, 32'd1);
    check("beq_res", ALU_result, 32'd0);
    op(4'd3, 32'd9, 32'd9);
    check("bne_zero", {31'd0, zero}, 32'd0);
    op(4'd7, 32'hFFFF_FFFF, 32'd1);
    check("bge_neg_zero", {31'd0, zero}, 32'd0);
    check("bge_neg_res", ALU_result, 32'hFFFF_FFFE);
    op(4'd7, 32'd1, 32'hFFFF_FFFF);
    check("bge_pos_zero", {31'd0, zero}, 32'd1);
    check("bge_pos_res", ALU_result, 32'd2);
    op(4'd8, 32'h1234_5678, 32'h9ABC_DEF0);
    check("unk_res", ALU_result, 32'd0);
    check("unk_zero", {31'd0, zero}, 32'd1);
    check("unk_ov", {31'd0, out_valid}, 32'd1);

    op(4'd1, 32'd7, 32'hFFFF_FFFD);
    check("mul_busy0", {31'd0, busy}, 32'd1);
    check("mul_ov0", {31'd0, out_valid}, 32'd0);
    // A different add held during the stall must be ignored.
    ALU_control = 4'd2;
    A           = 32'd100;
    B           = 32'd200;
    wait_done(bc, sv);
    check("mul_busy_cycles", bc, 32'd32);
    check("mul_stray_ov", sv, 32'd0);
    check("mul_ov", {31'd0, out_valid}, 32'd1);
    check("mul_res", ALU_result, 32'hFFFF_FFEB);
    check("mul_zero", {31'd0, zero}, 32'd0);
    in_valid = 1'b0;
    tick();
    check("mul_after_ov", {31'd0, out_valid}, 32'd0);
    check("mul_after_res", ALU_result, 32'hFFFF_FFEB);

    op(4'd1, 32'h0001_0000, 32'h0001_0000);
    in_valid = 1'b0;
    wait_done(bc, sv);
    check("mul0_res", ALU_result, 32'd0);
    check("mul0_zero", {31'd0, zero}, 32'd1);
    check("mul0_ov", {31'd0, out_valid}, 32'd1);

    op(4'd1, 32'd3, 32'd5);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ov", {31'd0, out_valid}, 32'd0);
    check("abort_res", ALU_result, 32'd0);
    rst = 1'b0;
    tick();
    check("abort_ov2", {31'd0, out_valid}, 32'd0);
    op(4'd2, 32'd2, 32'd3);
    check("add23_res", ALU_result, 32'd5);
    check("add23_ov", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("add23_ov_end", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
